pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parameterised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and control-bit squashing. It is the general pipeline stage that sits between any two processor stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a data bundle and a control bundle with one cycle of latency, and supports stalls from either side without combinational ready paths. Control bits are never visible while the stage holds no valid entry, so a bubble cannot cause a register write, memory access or halt.

## Interface
Parameters:
- DATA_W, 48, width of the data bundle (e.g. readData2, ALURes, nextPC); must be ≥1
- CTRL_W, 8, width of the control bundle (e.g. writeReg, regWrite, memToReg, memRead, memWrite, halt); must be ≥1

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous discard of all held entries
- in_valid  input  1  upstream presents an entry
- in_ready  output  1  stage can accept an entry; driven directly from a register
- in_data  input  DATA_W  upstream data bundle
- in_ctrl  input  CTRL_W  upstream control bundle
- out_valid  output  1  stage presents an entry
- out_ready  input  1  downstream accepts the entry
- out_data  output  DATA_W  data of the head entry
- out_ctrl  output  CTRL_W  control of the head entry, forced to 0 when out_valid=0
- count  output  2  number of held entries (0..2)

## Operation
- Entries: a main register (head, drives out_*) and a skid register.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State EMPTY (count=0): out_valid=0, in_ready=1.
  - in_fire -> ONE, main<=in.
- State ONE (count=1): out_valid=1, in_ready=1.
  - in_fire & out_fire -> ONE, main<=in.
  - in_fire & !out_fire -> TWO, skid<=in.
  - !in_fire & out_fire -> EMPTY.
  - Neither -> hold.
- State TWO (count=2): out_valid=1, in_ready=0.
  - out_fire -> ONE, main<=skid.
  - Otherwise hold.
  - in_valid is ignored in this state.
- flush=1 has priority over every other event:
  - next state EMPTY.
  - An in_fire in the same cycle is dropped.
  - An out_fire in the same cycle still completes downstream; the entry is not re-presented.
- Output gating:
  - out_ctrl = main_ctrl when out_valid, otherwise all zeros.
  - out_data = main_data regardless of valid; its value is don't-care when out_valid=0.
- Ordering: entries leave in strict acceptance order. Nothing is lost or duplicated except by flush.
- Data and control are passed through unmodified; there is no arithmetic.

## Timing
- Reset (rst=0, asynchronous):
  - state EMPTY, count=0.
  - out_valid=0, in_ready=1, out_ctrl=0, out_data=0.
  - Main and skid registers cleared to 0.
  - Takes effect mid-transfer without waiting for clk; all held entries are lost.
- Release: the first accept can occur on the first rising edge after rst goes high.
- Latency: an entry accepted at edge N is presented (out_valid=1) immediately after edge N, i.e. one cycle.
- Throughput: one entry per cycle sustained while out_ready=1.
- Backpressure timing:
  - When out_ready drops, in_ready stays 1 for one more cycle; that cycle's entry goes to skid.
  - in_ready falls after the edge that fills skid.
- in_ready depends only on registered state. No combinational path from out_ready or in_valid to in_ready.
- Combinational outputs: out_valid and out_ctrl are functions of registered state only.
- Flush: after the flush edge, out_valid=0, count=0, in_ready=1. A new entry can be accepted on the next edge.

## Test plan
- Reset/idle:
  - Stimulus: assert rst=0 mid-cycle while count=2.
  - Response: immediately out_valid=0, count=0, in_ready=1, out_ctrl=0, out_data=0.
- Streaming:
  - Stimulus: out_ready=1; send in_data=0x000001..0x000010 back-to-back, in_ctrl=0x80|i.
  - Response: each entry appears exactly one cycle later, in order, no gaps; count stays 1.
- Skid fill/drain:
  - Stimulus: stream A,B,C,D with out_ready=0 from the cycle A is presented.
  - Response: A held in main, B in skid, count=2, in_ready=0. C is not accepted until out_ready=1.
  - Then A, B, C, D are delivered in order with no loss or duplication.
- Flush priority:
  - Stimulus: count=2 (A,B held); assert flush together with in_valid=1 (C) and out_ready=1.
  - Response: A counts as delivered that cycle; B and C are discarded; next cycle count=0, out_valid=0, out_ctrl=0.
- Bubble squash:
  - Stimulus: in_ctrl=0xFF with in_valid=0 for 3 cycles.
  - Response: out_valid=0 and out_ctrl=0x00 throughout.
- Random handshake:
  - Stimulus: 10,000 cycles of random in_valid, out_ready and flush (flush at 2%).
  - Response, checked against a scoreboard:
    - Order preserved; only flushed entries are missing.
    - in_ready == (count != 2).

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with valid/ready handshake, two-entry skid buffer, flush and control squashing
//   clk, rst (async active-low), flush (sync discard of held entries)
//   in_valid/in_ready/in_data/in_ctrl    upstream side, in_ready comes straight from a flop
//   out_valid/out_ready/out_data/out_ctrl downstream side, out_ctrl zeroed while out_valid=0
//   count                                 held entries 0..2
module pipe_stage_skid #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
  state_e state_q, state_d;
  logic ready_q;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic in_fire, out_fire;
  assign out_valid = state_q != EMPTY;
  assign in_ready  = ready_q;
  assign in_fire   = in_valid & ready_q;
  assign out_fire  = out_valid & out_ready;
  assign count     = state_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    case (state_q)
      EMPTY: if (in_fire) begin
        state_d     = ONE;
        main_data_d = in_data;
        main_ctrl_d = in_ctrl;
      end
      ONE: if (in_fire && out_fire) begin
        main_data_d = in_data;
        main_ctrl_d = in_ctrl;
      end else if (in_fire) begin
        state_d     = TWO;
        skid_data_d = in_data;
        skid_ctrl_d = in_ctrl;
      end else if (out_fire) begin
        state_d = EMPTY;
      end
      TWO: if (out_fire) begin
        state_d     = ONE;
        main_data_d = skid_data_q;
        main_ctrl_d = skid_ctrl_q;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end
  // ready is registered from the next state so no path exists from out_ready/in_valid to in_ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      ready_q     <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= state_d != TWO;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scoreboard bench for pipe_stage_skid with directed and random handshake stimulus
module tb_pipe_stage_skid;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [47:0] in_data = '0, out_data;
  logic [7:0] in_ctrl = '0, out_ctrl;
  logic [1:0] count;
  int checks = 0, errors = 0;
  int m_cnt = 0;
  bit pa = 0, pd = 0, pf = 0, mon_en = 0;
  logic [55:0] exp_q[$];

  pipe_stage_skid #(.DATA_W(48), .CTRL_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      if (errors < 30) $display("FAIL %s got %0h want %0h at %0t", n, got, want, $time);
    end
  endtask

  // Model: a stage holds up to two entries; it accepts whenever it holds fewer than two,
  // delivers its oldest when out_ready, and flush empties it after this cycle's delivery.
  task automatic step(input bit v, input logic [47:0] d, input logic [7:0] c, input bit ordy, input bit fl);
    @(negedge clk);
    m_cnt = pf ? 0 : m_cnt + int'(pa) - int'(pd);
    in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl;
    pa = v && (m_cnt < 2);
    pd = ordy && (m_cnt > 0);
    pf = fl;
    if (pa && !fl) exp_q.push_back({c, d});
  endtask

  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      chk("count", 64'(count), 64'(m_cnt));
      chk("in_ready", 64'(in_ready), 64'(m_cnt != 2));
      chk("out_valid", 64'(out_valid), 64'(m_cnt != 0));
      if (!out_valid) chk("squash", 64'(out_ctrl), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
        else chk("order", 64'({out_ctrl, out_data}), 64'(exp_q.pop_front()));
      end
      if (flush) exp_q.delete();
    end
  end

  initial begin
    logic [63:0] r;
    repeat (2) @(negedge clk);
    rst = 1;
    mon_en = 1;
    for (int i = 1; i <= 16; i++) step(1, 48'(i), 8'h80 | 8'(i), 1, 0);
    repeat (2) step(0, '0, '0, 1, 0);
    step(1, 48'hA, 8'h0A, 1, 0);
    step(1, 48'hB, 8'h0B, 0, 0);
    repeat (2) step(1, 48'hC, 8'h0C, 0, 0);
    step(1, 48'hC, 8'h0C, 1, 0);
    step(1, 48'hC, 8'h0C, 1, 0);
    step(1, 48'hD, 8'h0D, 1, 0);
    repeat (3) step(0, '0, '0, 1, 0);
    step(1, 48'h1A, 8'h1A, 0, 0);
    step(1, 48'h1B, 8'h1B, 0, 0);
    step(1, 48'h1C, 8'h1C, 1, 1);
    repeat (2) step(0, '0, '0, 1, 0);
    repeat (3) step(0, 48'hFFFF, 8'hFF, 0, 0);
    for (int i = 0; i < 10000; i++) begin
      r = {$urandom, $urandom};
      step(1'($urandom % 2), r[47:0], 8'($urandom), 1'($urandom % 2), ($urandom % 100) < 2);
    end
    repeat (4) step(0, '0, '0, 1, 0);
    @(negedge clk);
    #3;
    chk("drained", 64'(exp_q.size()), 64'd0);
    mon_en = 0;
    step(1, 48'h2A, 8'h2A, 0, 0);
    step(1, 48'h2B, 8'h2B, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_reset_count", 64'(count), 64'd2);
    rst = 0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
